// File: rtl/pwr_seq_pkg.sv
// rtl/pwr_seq_pkg.sv - state encoding and default timing for the retention sequencer
package pwr_seq_pkg;

   typedef enum logic [3:0] {
      ST_ON      = 4'd0,
      ST_CLK_OFF = 4'd1,
      ST_ISO_ON  = 4'd2,
      ST_SAVE    = 4'd3,
      ST_SW_OFF  = 4'd4,
      ST_OFF     = 4'd5,
      ST_SW_ON   = 4'd6,
      ST_RESTORE = 4'd7,
      ST_ISO_OFF = 4'd8,
      ST_CLK_ON  = 4'd9,
      ST_FAULT   = 4'd10
   } pwr_state_e;

   localparam int DEF_CLK_DLY     = 2;
   localparam int DEF_ISO_DLY     = 2;
   localparam int DEF_SAVE_CYCLES = 3;
   localparam int DEF_ACK_TIMEOUT = 16;

   function automatic int max_of4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// rtl/pwr_seq_timer.sv - loadable down-counter; expired while the count sits at zero
module pwr_seq_timer
   import pwr_seq_pkg::*;
#(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/pwr_retention_seq.sv
// rtl/pwr_retention_seq.sv - power-gating / retention sequencer for one switchable domain
module pwr_retention_seq
   import pwr_seq_pkg::*;
#(
   parameter int CLK_DLY     = DEF_CLK_DLY,
   parameter int ISO_DLY     = DEF_ISO_DLY,
   parameter int SAVE_CYCLES = DEF_SAVE_CYCLES,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pwr_down_req,
   input  logic       pwr_up_req,
   input  logic       pwr_ack,
   output logic       clk_en,
   output logic       iso_en,
   output logic       save,
   output logic       restore,
   output logic       pwr_en,
   output logic       busy,
   output logic       done,
   output logic       ret_valid,
   output logic       fault,
   output logic [3:0] state
);

   localparam int CNT_W = $clog2(max_of4(CLK_DLY, ISO_DLY, SAVE_CYCLES, ACK_TIMEOUT)) + 1;

   // A state lasting N cycles loads N-1 and leaves on the edge that finds zero.
   localparam logic [CNT_W-1:0] LD_CLK  = CNT_W'(CLK_DLY - 1);
   localparam logic [CNT_W-1:0] LD_ISO  = CNT_W'(ISO_DLY - 1);
   localparam logic [CNT_W-1:0] LD_SAVE = CNT_W'(SAVE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_ACK  = CNT_W'(ACK_TIMEOUT - 1);

   pwr_state_e       cur, nxt;
   logic             tmr_load, tmr_exp;
   logic [CNT_W-1:0] tmr_val;
   logic             n_done, n_ret;

   pwr_seq_timer #(.W(CNT_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_exp)
   );

   always_comb begin
      nxt = cur;
      case (cur)
         ST_ON:      if (pwr_down_req) nxt = ST_CLK_OFF;
         ST_CLK_OFF: if (tmr_exp) nxt = ST_ISO_ON;
         ST_ISO_ON:  if (tmr_exp) nxt = ST_SAVE;
         ST_SAVE:    if (tmr_exp) nxt = ST_SW_OFF;
         ST_SW_OFF:  if (!pwr_ack) nxt = ST_OFF;
                     else if (tmr_exp) nxt = ST_FAULT;
         ST_OFF:     if (pwr_up_req) nxt = ST_SW_ON;
         ST_SW_ON:   if (pwr_ack) nxt = ST_RESTORE;
                     else if (tmr_exp) nxt = ST_FAULT;
         ST_RESTORE: if (tmr_exp) nxt = ST_ISO_OFF;
         ST_ISO_OFF: if (tmr_exp) nxt = ST_CLK_ON;
         ST_CLK_ON:  if (tmr_exp) nxt = ST_ON;
         default:    nxt = ST_FAULT;
      endcase

      tmr_load = (nxt != cur);
      case (nxt)
         ST_CLK_OFF, ST_CLK_ON: tmr_val = LD_CLK;
         ST_ISO_ON,  ST_ISO_OFF: tmr_val = LD_ISO;
         ST_SAVE,    ST_RESTORE: tmr_val = LD_SAVE;
         ST_SW_OFF,  ST_SW_ON:   tmr_val = LD_ACK;
         default:               tmr_val = '0;
      endcase

      n_done = ((cur == ST_CLK_ON) && (nxt == ST_ON)) ||
               ((cur == ST_SW_OFF) && (nxt == ST_OFF));

      n_ret = ret_valid;
      if ((cur == ST_SAVE) && (nxt == ST_SW_OFF))
         n_ret = 1'b1;
      else if ((cur == ST_RESTORE) && (nxt == ST_ISO_OFF))
         n_ret = 1'b0;
   end

   // Outputs are decoded from the next state so they change on the entry edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur       <= ST_ON;
         clk_en    <= 1'b1;
         iso_en    <= 1'b0;
         save      <= 1'b0;
         restore   <= 1'b0;
         pwr_en    <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         ret_valid <= 1'b0;
         fault     <= 1'b0;
      end else begin
         cur       <= nxt;
         clk_en    <= (nxt inside {ST_ON, ST_CLK_ON});
         iso_en    <= (nxt inside {ST_ISO_ON, ST_SAVE, ST_SW_OFF, ST_OFF,
                                   ST_SW_ON, ST_RESTORE, ST_FAULT});
         save      <= (nxt == ST_SAVE);
         restore   <= (nxt == ST_RESTORE);
         pwr_en    <= !(nxt inside {ST_SW_OFF, ST_OFF, ST_FAULT});
         busy      <= !(nxt inside {ST_ON, ST_OFF, ST_FAULT});
         done      <= n_done;
         ret_valid <= n_ret;
         fault     <= (nxt == ST_FAULT);
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_pwr_retention_seq.sv
// tb/tb_pwr_retention_seq.sv - scoreboard bench for pwr_retention_seq
module tb_pwr_retention_seq;

   localparam int P_CLK  = 2;
   localparam int P_ISO  = 2;
   localparam int P_SAVE = 3;
   localparam int P_ACK  = 16;

   localparam int S_ON = 0, S_CLK_OFF = 1, S_ISO_ON = 2, S_SAVE = 3, S_SW_OFF = 4,
                  S_OFF = 5, S_SW_ON = 6, S_RESTORE = 7, S_ISO_OFF = 8,
                  S_CLK_ON = 9, S_FAULT = 10;

   typedef struct packed {
      logic [3:0] st;
      logic clk_en, iso_en, save, restore, pwr_en, busy, done, ret_valid, fault;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pwr_down_req = 1'b0, pwr_up_req = 1'b0, pwr_ack = 1'b1;
   logic clk_en, iso_en, save, restore, pwr_en, busy, done, ret_valid, fault;
   logic [3:0] state;

   vec_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   m_st = S_ON;
   bit   m_ret = 1'b0;

   always #5 clk = ~clk;

   pwr_retention_seq #(
      .CLK_DLY(P_CLK), .ISO_DLY(P_ISO), .SAVE_CYCLES(P_SAVE), .ACK_TIMEOUT(P_ACK)
   ) dut (
      .clk(clk), .rst(rst), .pwr_down_req(pwr_down_req), .pwr_up_req(pwr_up_req),
      .pwr_ack(pwr_ack), .clk_en(clk_en), .iso_en(iso_en), .save(save),
      .restore(restore), .pwr_en(pwr_en), .busy(busy), .done(done),
      .ret_valid(ret_valid), .fault(fault), .state(state)
   );

   // Expected pin values of a state, straight from the operating rules.
   function automatic vec_t mk(input int st, input bit dn, input bit ret);
      vec_t v;
      v.st        = 4'(st);
      v.clk_en    = (st == S_ON) || (st == S_CLK_ON);
      v.iso_en    = (st >= S_ISO_ON && st <= S_RESTORE) || (st == S_FAULT);
      v.save      = (st == S_SAVE);
      v.restore   = (st == S_RESTORE);
      v.pwr_en    = !(st == S_SW_OFF || st == S_OFF || st == S_FAULT);
      v.busy      = !(st == S_ON || st == S_OFF || st == S_FAULT);
      v.done      = dn;
      v.ret_valid = ret;
      v.fault     = (st == S_FAULT);
      return v;
   endfunction

   initial begin : monitor
      vec_t e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, clk_en, iso_en, save, restore, pwr_en, busy, done, ret_valid, fault};
            vectors++;
            if (a !== e) begin
               miscompares++;
               $display("FAIL vec%0d st/clk_en/iso_en/save/restore/pwr_en/busy/done/ret_valid/fault got=%0d/%b%b%b%b%b%b%b%b%b exp=%0d/%b%b%b%b%b%b%b%b%b",
                        vectors, a.st, a.clk_en, a.iso_en, a.save, a.restore, a.pwr_en, a.busy,
                        a.done, a.ret_valid, a.fault, e.st, e.clk_en, e.iso_en, e.save,
                        e.restore, e.pwr_en, e.busy, e.done, e.ret_valid, e.fault);
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      pwr_down_req = 1'($urandom);
      pwr_up_req = 1'($urandom);
      @(posedge clk); #1;
      exp_q.push_back(mk(S_ON, 1'b0, 1'b0));
      m_st = S_ON;
      m_ret = 1'b0;
      rst = 1'b0;
   endtask

   // Idle in a resting state; only the request that state ignores is toggled.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         pwr_down_req = (m_st == S_ON) ? 1'b0 : 1'($urandom);
         pwr_up_req   = (m_st == S_OFF) ? 1'b0 : 1'($urandom);
         pwr_ack      = 1'($urandom);
         @(posedge clk); #1;
         exp_q.push_back(mk(m_st, 1'b0, m_ret));
      end
   endtask

   // Whole sequence laid out as a state timeline; d = sampled ack edges before the ack arrives.
   task automatic run_seq(input bit up, input int d, input int abort_at);
      int sq[$];
      int n_ack;
      n_ack = (d < P_ACK) ? d + 1 : P_ACK;
      if (!up) begin
         repeat (P_CLK)  sq.push_back(S_CLK_OFF);
         repeat (P_ISO)  sq.push_back(S_ISO_ON);
         repeat (P_SAVE) sq.push_back(S_SAVE);
         repeat (n_ack)  sq.push_back(S_SW_OFF);
         sq.push_back((d < P_ACK) ? S_OFF : S_FAULT);
      end else begin
         repeat (n_ack) sq.push_back(S_SW_ON);
         if (d < P_ACK) begin
            repeat (P_SAVE) sq.push_back(S_RESTORE);
            repeat (P_ISO)  sq.push_back(S_ISO_OFF);
            repeat (P_CLK)  sq.push_back(S_CLK_ON);
            sq.push_back(S_ON);
         end else
            sq.push_back(S_FAULT);
      end
      for (int k = 0; k < sq.size(); k++) begin
         rst = (k == abort_at);
         if (!up) begin
            pwr_down_req = (k == 0) ? 1'b1 : 1'($urandom);
            pwr_up_req   = (k < P_CLK + P_ISO + P_SAVE) ? 1'b1 : 1'($urandom);
            pwr_ack      = (k < P_CLK + P_ISO + P_SAVE + 1 + d);
         end else begin
            pwr_up_req   = (k == 0) ? 1'b1 : 1'($urandom);
            pwr_down_req = 1'($urandom);
            pwr_ack      = (k >= 1 + d);
         end
         @(posedge clk); #1;
         if (rst) begin
            exp_q.push_back(mk(S_ON, 1'b0, 1'b0));
            m_st = S_ON;
            m_ret = 1'b0;
            rst = 1'b0;
            return;
         end
         if (!up && sq[k] == S_SW_OFF) m_ret = 1'b1;
         if (up && sq[k] == S_ISO_OFF) m_ret = 1'b0;
         m_st = sq[k];
         exp_q.push_back(mk(sq[k], (k == sq.size() - 1) && (m_st == S_ON || m_st == S_OFF), m_ret));
      end
   endtask

   initial begin : stimulus
      do_reset();
      do_reset();
      idle(3);
      run_seq(1'b0, 0, -1);
      idle(2);
      run_seq(1'b1, 0, -1);
      for (int i = 0; i < 6; i++) begin
         idle($urandom_range(0, 3));
         run_seq(1'b0, $urandom_range(0, 5), -1);
         idle($urandom_range(0, 3));
         run_seq(1'b1, $urandom_range(0, 5), -1);
      end
      run_seq(1'b0, P_ACK - 1, -1);
      run_seq(1'b1, P_ACK - 1, -1);
      run_seq(1'b0, 0, P_CLK + P_ISO + $urandom_range(0, P_SAVE - 1));
      idle(2);
      run_seq(1'b0, P_ACK, -1);
      idle(5);
      do_reset();
      run_seq(1'b0, 1, -1);
      run_seq(1'b1, P_ACK, -1);
      idle(4);
      do_reset();
      idle(2);
      repeat (2) @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
